// File: rtl/trail_pkg.sv
// Shared types and constants for the light-cycle trail grid: FSM states,
// game-state and direction encodings, and the cell-code helper.
package trail_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_READ,
        ST_CHECK,
        ST_WRITE
    } state_t;

    localparam logic [2:0] GS_CLEAR = 3'b001;
    localparam logic [2:0] GS_PLAY  = 3'b010;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    // 0 empty, 2p+1 horizontal, 2p+2 vertical, 2N+1 corner (shared by all players).
    function automatic int trail_code(input int player, input logic [1:0] d,
                                      input logic corner, input int num_players);
        if (corner)
            return 2 * num_players + 1;
        if (d == DIR_UP || d == DIR_DOWN)
            return 2 * player + 2;
        return 2 * player + 1;
    endfunction

endpackage

// File: rtl/trail_ram.sv
// Simple dual-port cell RAM: port A read/write for the update FSM, port B
// read-only for the renderer. Both reads registered, read-old-data on collision.
module trail_ram #(
    parameter int DEPTH  = 12544,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 3
) (
    input  logic              i_clk,
    input  logic              i_a_we,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_wdata,
    output logic [DATA_W-1:0] o_a_rdata,
    input  logic [ADDR_W-1:0] i_b_addr,
    output logic [DATA_W-1:0] o_b_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // NOTE: no reset on the array so it maps onto block RAM; the FSM sweeps it clear instead.
    always_ff @(posedge i_clk) begin
        if (i_a_we)
            r_mem[i_a_addr] <= i_a_wdata;
        o_a_rdata <= r_mem[i_a_addr];
        o_b_rdata <= r_mem[i_b_addr];
    end

endmodule

// File: rtl/trail_grid.sv
// Trail grid: records each player's path into a cell RAM once per frame tick.
// Define TRAIL_COLLISION_EN to enable the sticky per-player collision flags.
module trail_grid
    import trail_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int GRID_W      = 112,
    parameter int GRID_H      = 112,
    parameter int COORD_W     = 7,
    parameter int CODE_W      = 3
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           frame_clk,
    input  logic [2:0]                     Game_State,
    input  logic [NUM_PLAYERS*COORD_W-1:0] pos_x,
    input  logic [NUM_PLAYERS*COORD_W-1:0] pos_y,
    input  logic [NUM_PLAYERS*2-1:0]       dir,
    input  logic [COORD_W-1:0]             rd_x,
    input  logic [COORD_W-1:0]             rd_y,
    output logic [CODE_W-1:0]              rd_code,
    output logic [NUM_PLAYERS-1:0]         collision,
    output logic                           busy
);

    localparam int DEPTH  = GRID_W * GRID_H;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PW     = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(GRID_W) + ADDR_W'(x);
    endfunction

    state_t                r_state, w_next;
    logic [2:0]            r_fsync;
    logic                  w_frame_req;
    logic                  r_init_pend;
    logic [ADDR_W-1:0]     r_clr_addr;
    logic [PW-1:0]         r_player;
    logic [NUM_PLAYERS-1:0] r_prev_valid;
    logic [COORD_W-1:0]    r_prev_x   [NUM_PLAYERS];
    logic [COORD_W-1:0]    r_prev_y   [NUM_PLAYERS];
    logic [1:0]            r_prev_dir [NUM_PLAYERS];
    logic [COORD_W-1:0]    w_px [NUM_PLAYERS];
    logic [COORD_W-1:0]    w_py [NUM_PLAYERS];
    logic [1:0]            w_pd [NUM_PLAYERS];
    logic [COORD_W-1:0]    w_cx, w_cy;
    logic [1:0]            w_cd;
    logic                  w_moved, w_inb, w_last, w_rd_inb;
    logic [CODE_W-1:0]     w_code;
    logic                  w_a_we;
    logic [ADDR_W-1:0]     w_a_addr, w_b_addr;
    logic [CODE_W-1:0]     w_a_wdata, w_a_rdata;

    // Bits 0/1 synchronise frame_clk; bit 2 is the delayed copy for edge detection.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_fsync <= '0;
        else
            r_fsync <= {r_fsync[1:0], frame_clk};
    end
    assign w_frame_req = r_fsync[1] & ~r_fsync[2];

    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_px[p] = pos_x[p*COORD_W +: COORD_W];
            w_py[p] = pos_y[p*COORD_W +: COORD_W];
            w_pd[p] = dir[p*2 +: 2];
        end
    end

    assign w_cx    = w_px[r_player];
    assign w_cy    = w_py[r_player];
    assign w_cd    = w_pd[r_player];
    assign w_inb   = (int'(w_cx) < GRID_W) && (int'(w_cy) < GRID_H);
    assign w_moved = r_prev_valid[r_player] &&
                     ((r_prev_x[r_player] != w_cx) || (r_prev_y[r_player] != w_cy));
    assign w_last  = (r_player == PW'(NUM_PLAYERS - 1));
    assign w_code  = CODE_W'(trail_code(int'(r_player), w_cd,
                                        w_cd != r_prev_dir[r_player], NUM_PLAYERS));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // NOTE: default assignment first so no path through the case leaves w_next unassigned (latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_init_pend || Game_State == GS_CLEAR)
                    w_next = ST_CLEAR;
                else if (w_frame_req && Game_State == GS_PLAY)
                    w_next = ST_READ;
            end
            ST_CLEAR: if (r_clr_addr == LAST_ADDR) w_next = ST_IDLE;
            ST_READ:  w_next = ST_CHECK;
            ST_CHECK: w_next = ST_WRITE;
            ST_WRITE: w_next = w_last ? ST_IDLE : ST_READ;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Reset leaves init pending, so the RAM is always swept from address 0 after release.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_init_pend  <= 1'b1;
            r_clr_addr   <= '0;
            r_player     <= '0;
            r_prev_valid <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_prev_x[p]   <= '0;
                r_prev_y[p]   <= '0;
                r_prev_dir[p] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_next == ST_CLEAR) begin
                        r_init_pend  <= 1'b0;
                        r_clr_addr   <= '0;
                        r_prev_valid <= '0;
                    end else if (w_next == ST_READ) begin
                        r_player <= '0;
                    end
                end
                ST_CLEAR: r_clr_addr <= r_clr_addr + ADDR_W'(1);
                ST_WRITE: begin
                    r_prev_x[r_player]     <= w_cx;
                    r_prev_y[r_player]     <= w_cy;
                    r_prev_dir[r_player]   <= w_cd;
                    r_prev_valid[r_player] <= 1'b1;
                    if (!w_last)
                        r_player <= r_player + PW'(1);
                end
                default: ;
            endcase
        end
    end

    assign w_a_we    = (r_state == ST_CLEAR) || (r_state == ST_WRITE && w_moved && w_inb);
    assign w_a_addr  = (r_state == ST_CLEAR) ? r_clr_addr : (w_inb ? cell_addr(w_cx, w_cy) : '0);
    assign w_a_wdata = (r_state == ST_CLEAR) ? '0 : w_code;
    assign w_rd_inb  = (int'(rd_x) < GRID_W) && (int'(rd_y) < GRID_H);
    assign w_b_addr  = w_rd_inb ? cell_addr(rd_x, rd_y) : '0;

    trail_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (CODE_W)
    ) u_ram (
        .i_clk     (Clk),
        .i_a_we    (w_a_we),
        .i_a_addr  (w_a_addr),
        .i_a_wdata (w_a_wdata),
        .o_a_rdata (w_a_rdata),
        .i_b_addr  (w_b_addr),
        .o_b_rdata (rd_code)
    );

`ifdef TRAIL_COLLISION_EN
    logic [NUM_PLAYERS-1:0] r_collision, w_hit_mask;

    // Head-on only counts once p has a latched previous position, so the first frame flags nothing.
    always_comb begin
        w_hit_mask = '0;
        if (w_moved && (!w_inb || w_a_rdata != '0))
            w_hit_mask[r_player] = 1'b1;
        if (r_prev_valid[r_player]) begin
            for (int q = 0; q < NUM_PLAYERS; q++) begin
                if (PW'(q) < r_player && w_px[q] == w_cx && w_py[q] == w_cy) begin
                    w_hit_mask[q]        = 1'b1;
                    w_hit_mask[r_player] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_collision <= '0;
        else if (r_state == ST_IDLE && w_next == ST_CLEAR)
            r_collision <= '0;
        else if (r_state == ST_CHECK)
            r_collision <= r_collision | w_hit_mask;
    end

    assign collision = r_collision;
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^w_a_rdata;
    assign collision      = '0;
`endif

    assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_trail_grid.sv
// Directed scoreboard bench for trail_grid: clear sweep, trail codes, corners,
// collisions (when TRAIL_COLLISION_EN is defined), out-of-bounds and reset abort.
module tb_trail_grid;
    import trail_pkg::*;

    localparam int NP  = 2;
    localparam int CW  = 7;
    localparam int CDW = 3;
`ifdef TRAIL_COLLISION_EN
    localparam logic [NP-1:0] CM = '1;
`else
    localparam logic [NP-1:0] CM = '0;
`endif

    logic              Clk = 1'b0;
    logic              Reset;
    logic              frame_clk;
    logic [2:0]        Game_State;
    logic [NP*CW-1:0]  pos_x, pos_y;
    logic [NP*2-1:0]   dir;
    logic [CW-1:0]     rd_x, rd_y;
    logic [CDW-1:0]    rd_code;
    logic [NP-1:0]     collision;
    logic              busy;

    logic [31:0] exp_q[$];
    logic [31:0] col_q[$];
    int          vectors     = 0;
    int          miscompares = 0;

    trail_grid dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .Game_State (Game_State),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .dir        (dir),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_code    (rd_code),
        .collision  (collision),
        .busy       (busy)
    );

    always #10 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic set_players(input int x0, input int y0, input int d0,
                               input int x1, input int y1, input int d1);
        pos_x = {CW'(x1), CW'(x0)};
        pos_y = {CW'(y1), CW'(y0)};
        dir   = {2'(d1), 2'(d0)};
    endtask

    task automatic expect_cell(input string tag, input int x, input int y, input int code);
        exp_q.push_back(32'(code));
        @(negedge Clk);
        rd_x = CW'(x);
        rd_y = CW'(y);
        @(negedge Clk);
        check(tag, 32'(rd_code), exp_q.pop_front());
    endtask

    task automatic wait_level(input logic level, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (busy === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Waits for busy, then counts its high cycles; optionally pulses frame_clk mid-way.
    task automatic count_busy(input string tag, input int exp_n, input logic [2:0] gs_after,
                              input int frame_at);
        logic ok;
        int   n;
        exp_q.push_back(32'd1);
        wait_level(1'b1, 10, ok);
        check({tag, "_start"}, 32'(ok), exp_q.pop_front());
        if (ok) begin
            Game_State = gs_after;
            exp_q.push_back(32'(exp_n));
            n = 1;
            for (int i = 0; i < 20000; i++) begin
                @(negedge Clk);
                if (frame_at > 0 && n == frame_at)     frame_clk = 1'b1;
                if (frame_at > 0 && n == frame_at + 3) frame_clk = 1'b0;
                if (!busy) break;
                n++;
            end
            check(tag, 32'(n), exp_q.pop_front());
        end
    endtask

    task automatic do_frame(input string tag, input int x0, input int y0, input int d0,
                            input int x1, input int y1, input int d1, input logic [NP-1:0] exp_col);
        @(negedge Clk);
        set_players(x0, y0, d0, x1, y1, d1);
        Game_State = GS_PLAY;
        col_q.push_back(32'(exp_col & CM));
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        count_busy({tag, "_len"}, 3 * NP, GS_PLAY, 0);
        @(negedge Clk);
        check({tag, "_col"}, 32'(collision), col_q.pop_front());
        repeat (3) @(negedge Clk);
    endtask

    task automatic do_clear(input string tag, input logic [2:0] gs_after, input int frame_at);
        logic ok;
        @(negedge Clk);
        Game_State = GS_CLEAR;
        count_busy({tag, "_len"}, 112 * 112, gs_after, frame_at);
        frame_clk = 1'b0;
        exp_q.push_back(32'd0);
        wait_level(1'b1, 20, ok);
        check({tag, "_no_update"}, 32'(ok), exp_q.pop_front());
        col_q.push_back(32'd0);
        check({tag, "_col"}, 32'(collision), col_q.pop_front());
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        Reset      = 1'b1;
        frame_clk  = 1'b0;
        Game_State = 3'b000;
        rd_x       = '0;
        rd_y       = '0;
        set_players(0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge Clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_col", 32'(collision), 32'd0);
        Reset = 1'b0;
        count_busy("boot_clear", 112 * 112, 3'b000, 0);
        expect_cell("boot_0_0", 0, 0, 0);
        expect_cell("boot_111_111", 111, 111, 0);
        expect_cell("boot_55_60", 55, 60, 0);

        // Straight runs and corners.
        do_frame("f1", 10, 10, 3, 20, 20, 0, 2'b00);
        expect_cell("f1_first_no_write", 20, 20, 0);
        do_frame("f2", 11, 10, 3, 20, 19, 2, 2'b00);
        expect_cell("blue_horiz", 11, 10, 1);
        expect_cell("red_corner", 20, 19, 5);
        expect_cell("blue_start_empty", 10, 10, 0);
        do_frame("f3", 12, 10, 3, 20, 18, 0, 2'b00);
        do_frame("f4", 13, 10, 3, 20, 17, 0, 2'b00);
        expect_cell("red_corner2", 20, 18, 5);
        expect_cell("red_vert", 20, 17, 4);

        // Red lands on blue's trail; the flag stays until CLEAR.
        do_frame("f5", 14, 10, 3, 13, 10, 2, 2'b10);
        expect_cell("red_overwrites", 13, 10, 5);
        do_frame("f6", 15, 10, 3, 13, 10, 2, 2'b10);
        do_frame("f7", 16, 10, 3, 13, 10, 2, 2'b10);
        do_frame("f8", 17, 10, 3, 13, 10, 2, 2'b10);
        expect_cell("blue_trail_f8", 17, 10, 1);

        // Clear with a frame tick landing mid-sweep: the tick must be dropped.
        set_players(40, 40, 3, 41, 41, 3);
        do_clear("clr1", GS_PLAY, 100);
        expect_cell("clr1_cell_a", 11, 10, 0);
        expect_cell("clr1_cell_b", 13, 10, 0);

        // Head-on at (30,30).
        do_frame("f9", 29, 30, 3, 31, 30, 2, 2'b00);
        do_frame("f10", 30, 30, 3, 30, 30, 2, 2'b11);
        expect_cell("headon_cell", 30, 30, 3);

        // Blue leaves the grid at X=112: flagged, and the aliased cell (0,41) stays empty.
        do_clear("clr2", 3'b000, 0);
        do_frame("f11", 111, 40, 3, 50, 50, 0, 2'b00);
        do_frame("f12", 112, 40, 3, 50, 50, 0, 2'b01);
        expect_cell("oob_alias_empty", 0, 41, 0);
        expect_cell("oob_prev_empty", 111, 40, 0);

        // Reset in the middle of an update aborts it and restarts the sweep.
        @(negedge Clk);
        set_players(60, 60, 0, 50, 50, 0);
        Game_State = GS_PLAY;
        frame_clk  = 1'b1;
        exp_q.push_back(32'd1);
        wait_level(1'b1, 10, ok);
        check("abort_update_start", 32'(ok), exp_q.pop_front());
        @(negedge Clk);
        Reset     = 1'b1;
        frame_clk = 1'b0;
        @(negedge Clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_col", 32'(collision), 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        count_busy("abort_reclear", 112 * 112, GS_PLAY, 0);
        col_q.push_back(32'd0);
        check("abort_col_after", 32'(collision), col_q.pop_front());
        expect_cell("abort_no_write", 60, 60, 0);
        expect_cell("abort_0_0", 0, 0, 0);
        expect_cell("abort_111_111", 111, 111, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
